// File: rtl/sub_shift_seq.sv
// SubBytes + ShiftRows stage of the AES round: rows are rotated when the block is captured,
// then the S-box is applied LANES bytes per cycle before the block is handed to MixColumns.
module sub_shift_seq #(
  parameter int LANES = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [1:0]   fsm_state
);

  localparam int NCHUNK = 16 / LANES;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_shift_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Handshake: a block moves on any edge where valid && ready. in_ready is a function of the
  // FSM state and out_ready only (never in_valid); out_valid and out_state come from flops.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  fsm_t         state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d, sub_data;
  logic         inv_q, inv_d;
  int           idx;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    int src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
        res[8*(15-(4*c+r)) +: 8] = s[8*(15-src) +: 8];
      end
    end
    return res;
  endfunction

  // Byte lanes cnt*LANES .. cnt*LANES+LANES-1 get their S-box image this cycle.
  always_comb begin
    sub_data = data_q;
    idx      = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = (int'(cnt_q) * LANES + l) % 16;
      sub_data[8*(15-idx) +: 8] = inv_q ? sbox_inv(data_q[8*(15-idx) +: 8])
                                        : sbox_fwd(data_q[8*(15-idx) +: 8]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    inv_d    = inv_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      SUB: begin
        data_d = sub_data;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(NCHUNK - 1)) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_ready && in_valid) begin
      data_d  = shift_rows(in_state, in_inverse);
      inv_d   = in_inverse;
      cnt_d   = 4'd0;
      state_d = SUB;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_state = data_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_sub_shift_seq.sv
// Directed bench for sub_shift_seq: reset, FIPS-197 vectors, backpressure, streaming against
// a reference S-box built with the generator-walk method, and a LANES sweep.
module tb_sub_shift_seq;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] ALL_63   = {16{8'h63}};

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inverse;
  logic         out_ready;
  logic         ir [5];
  logic         ov [5];
  logic [127:0] os [5];
  logic [1:0]   fs [5];

  int checks = 0;
  int errors = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];
  logic [127:0] exp_q [$];

  // Instance 2 (LANES = 4) is the main device; the others serve the LANES sweep.
  sub_shift_seq #(.LANES(1)) u_l1 (.clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .fsm_state(fs[0]));
  sub_shift_seq #(.LANES(2)) u_l2 (.clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .fsm_state(fs[1]));
  sub_shift_seq #(.LANES(4)) u_dut (.clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .fsm_state(fs[2]));
  sub_shift_seq #(.LANES(8)) u_l8 (.clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[3]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[3]), .out_ready(out_ready), .out_state(os[3]), .fsm_state(fs[3]));
  sub_shift_seq #(.LANES(16)) u_l16 (.clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[4]),
    .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[4]), .out_ready(out_ready), .out_state(os[4]), .fsm_state(fs[4]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] rol(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol(q, 1) ^ rol(q, 2) ^ rol(q, 3) ^ rol(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   b;
    int           sc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = (c + (inv ? 4 - r : r)) & 3;
        b  = s[127 - 8*(4*sc + r) -: 8];
        o[127 - 8*(4*c + r) -: 8] = inv ? isb[b] : sb[b];
      end
    end
    return o;
  endfunction

  task automatic send(input logic [127:0] s, input logic inv);
    @(negedge clock);
    in_state   = s;
    in_inverse = inv;
    in_valid   = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Edges from the transfer edge until out_valid is seen on the main device; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    forever begin
      @(negedge clock);
      if (ov[2]) break;
      @(posedge clock);
      lat++;
      if (lat > 40) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic drain();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int sent, got, cyc, last_out;
    int lat_s [5];
    int exp_lat [5];
    logic tin, tout, stuck;
    logic [127:0] first_hold;
    exp_lat = '{16, 8, 4, 2, 1};
    build_sbox();

    reset_n = 1'b0; in_valid = 1'b0; in_state = '0; in_inverse = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", 128'(ir[2]), 128'd1);
    chk("rst_out_valid", 128'(ov[2]), 128'd0);
    chk("rst_out_state", os[2], 128'd0);
    chk("rst_fsm_idle", 128'(fs[2]), 128'd0);
    reset_n = 1'b1;

    send(FIPS_IN, 1'b0);
    wait_valid(lat);
    chk("fwd_latency", 128'(lat), 128'd4);
    chk("fwd_fips", os[2], FIPS_OUT);
    chk("fwd_hold_in_ready", 128'(ir[2]), 128'd0);
    drain();
    @(negedge clock);
    chk("drain_out_valid", 128'(ov[2]), 128'd0);
    chk("drain_in_ready", 128'(ir[2]), 128'd1);

    send(FIPS_OUT, 1'b1);
    wait_valid(lat);
    chk("inv_latency", 128'(lat), 128'd4);
    chk("inv_fips", os[2], FIPS_IN);
    drain();

    send(ALL_63, 1'b1);
    wait_valid(lat);
    chk("inv_63", os[2], 128'd0);
    first_hold = os[2];
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_out_valid", 128'(ov[2]), 128'd1);
      chk("bp_out_stable", os[2], first_hold);
      chk("bp_in_ready", 128'(ir[2]), 128'd0);
    end
    @(negedge clock);
    out_ready = 1'b1; in_valid = 1'b1; in_state = '0; in_inverse = 1'b0;
    #1 chk("simul_in_ready", 128'(ir[2]), 128'd1);
    @(posedge clock);
    #1 begin out_ready = 1'b0; in_valid = 1'b0; end
    wait_valid(lat);
    chk("simul_latency", 128'(lat), 128'd4);
    chk("simul_fwd_zero", os[2], ALL_63);
    drain();

    sent = 0; got = 0; cyc = 0; last_out = -1;
    @(negedge clock);
    out_ready  = 1'b1;
    in_state   = {$urandom, $urandom, $urandom, $urandom};
    in_inverse = 1'($urandom_range(0, 1));
    in_valid   = 1'b1;
    while (got < 8 && cyc < 200) begin
      #1;
      tin  = in_valid && ir[2];
      tout = ov[2] && out_ready;
      if (tout) begin
        chk("stream_q_nonempty", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) chk("stream_data", os[2], exp_q.pop_front());
        if (last_out >= 0) chk("stream_interval", 128'(cyc - last_out), 128'd5);
        last_out = cyc;
        got++;
      end
      if (tin) begin
        exp_q.push_back(model(in_state, in_inverse));
        sent++;
      end
      @(posedge clock);
      #1;
      if (tin) begin
        if (sent < 8) begin
          in_state   = {$urandom, $urandom, $urandom, $urandom};
          in_inverse = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clock);
      cyc++;
    end
    chk("stream_count", 128'(got), 128'd8);
    out_ready = 1'b0;

    send(FIPS_IN, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(ov[2]), 128'd0);
    chk("midrst_fsm_idle", 128'(fs[2]), 128'd0);
    chk("midrst_out_state", os[2], 128'd0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    stuck = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (ov[2]) stuck = 1'b1;
    end
    chk("midrst_no_emit", 128'(stuck), 128'd0);
    out_ready = 1'b0;

    send(FIPS_IN, 1'b0);
    lat_s = '{-1, -1, -1, -1, -1};
    for (int j = 0; j <= 20; j++) begin
      @(negedge clock);
      for (int i = 0; i < 5; i++) if (lat_s[i] < 0 && ov[i]) lat_s[i] = j;
      @(posedge clock);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sweep_latency_%0d", i), 128'(lat_s[i]), 128'(exp_lat[i]));
      chk($sformatf("sweep_fips_%0d", i), os[i], FIPS_OUT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
